// File: rtl/mesh_pkt_pkg.sv
// rtl/mesh_pkt_pkg.sv - mesh packet header fields, pop FSM states and classification helpers
//
// Shared by the terminal sink, the injector stage and the testbench.
// Header layout from the packet MSB down: nxt_jump[8], dst_row[4], dst_col[4].
package mesh_pkt_pkg;

    localparam int NXT_W = 8;
    localparam int ROW_W = 4;
    localparam int COL_W = 4;
    localparam int HDR_W = NXT_W + ROW_W + COL_W;

    typedef struct packed {
        logic [NXT_W-1:0] nxt_jump;
        logic [ROW_W-1:0] dst_row;
        logic [COL_W-1:0] dst_col;
    } mesh_hdr_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } pop_state_e;

    function automatic logic is_bcast(mesh_hdr_t hdr, logic [NXT_W-1:0] bdcst);
        return hdr.nxt_jump == bdcst;
    endfunction

    // Broadcasts are never misrouted; a unicast must address this terminal exactly.
    function automatic logic is_misrouted(mesh_hdr_t hdr, logic [NXT_W-1:0] bdcst,
                                          logic [ROW_W-1:0] row_id, logic [COL_W-1:0] col_id);
        return !is_bcast(hdr, bdcst) && ((hdr.dst_row != row_id) || (hdr.dst_col != col_id));
    endfunction

endpackage

// File: rtl/term_sink_fifo.sv
// rtl/term_sink_fifo.sv - show-ahead circular FIFO for the terminal sink
//
// Ports:
//   clk, reset    : clock, synchronous active-low reset (discards contents)
//   push_i/data_i : enqueue request and entry; ignored while full_o
//   full_o        : no room, evaluated after this cycle's dequeue
//   pop_i         : dequeue request; ignored while empty
//   valid_o       : head entry valid (count != 0)
//   head_o        : head entry, zero while empty
module term_sink_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign valid_o = (count_q != '0);
    assign do_pop  = pop_i && valid_o;
    // A dequeue in the same cycle frees the slot, so a full buffer can still accept.
    assign full_o  = (count_q == (AW+1)'(DEPTH)) && !do_pop;
    assign do_push = push_i && !full_o;
    assign head_o  = valid_o ? mem_q[rd_q] : '0;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset: head_o is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/mesh_term_sink.sv
// rtl/mesh_term_sink.sv - mesh terminal egress: pop, classify, buffer, count
//
// Ports:
//   clk, reset                      : clock, synchronous active-low reset
//   pndng, data_out, pop            : mesh terminal show-ahead pop port
//   out_valid, out_ready            : local consumer handshake
//   out_data, out_bcast, out_err    : buffered head packet and its class flags
//   pkt_cnt, bcast_cnt, err_cnt     : saturating statistics counters
module mesh_term_sink
    import mesh_pkt_pkg::*;
#(
    parameter int         PAKG_SIZE  = 32,
    parameter int         ROWS       = 4,
    parameter int         COLUMNS    = 4,
    parameter logic [3:0] ROW_ID     = 4'd1,
    parameter logic [3:0] COL_ID     = 4'd0,
    parameter logic [7:0] BDCST      = 8'hFF,
    parameter int         SINK_DEPTH = 4,
    parameter int         CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pndng,
    input  logic [PAKG_SIZE-1:0] data_out,
    output logic                 pop,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAKG_SIZE-1:0] out_data,
    output logic                 out_bcast,
    output logic                 out_err,
    output logic [CNT_W-1:0]     pkt_cnt,
    output logic [CNT_W-1:0]     bcast_cnt,
    output logic [CNT_W-1:0]     err_cnt
);

    if (PAKG_SIZE < HDR_W + 2 || SINK_DEPTH < 2 || (SINK_DEPTH & (SINK_DEPTH - 1)) != 0
        || int'(ROW_ID) >= ROWS || int'(COL_ID) >= COLUMNS) begin : g_bad_cfg
        $error("mesh_term_sink: illegal parameter combination");
    end

    mesh_hdr_t        hdr;
    logic             in_bcast, in_err;
    logic             buf_full;
    logic             do_pop;
    pop_state_e       state_q;
    logic [CNT_W-1:0] pkt_cnt_q, bcast_cnt_q, err_cnt_q;

    assign hdr      = mesh_hdr_t'(data_out[PAKG_SIZE-1 -: HDR_W]);
    assign in_bcast = is_bcast(hdr, BDCST);
    assign in_err   = is_misrouted(hdr, BDCST, ROW_ID, COL_ID);

    // Gated by reset so no pop escapes to the mesh during the reset cycle.
    assign do_pop = reset && (state_q == ST_IDLE) && pndng && !buf_full;
    assign pop    = do_pop;

    function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v, logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    // SETTLE holds off one cycle because pndng only updates the cycle after pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pkt_cnt_q   <= '0;
            bcast_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (do_pop) begin
                        state_q <= ST_SETTLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            pkt_cnt_q   <= sat_inc(pkt_cnt_q,   do_pop);
            bcast_cnt_q <= sat_inc(bcast_cnt_q, do_pop && in_bcast);
            err_cnt_q   <= sat_inc(err_cnt_q,   do_pop && in_err);
        end
    end

    term_sink_fifo #(
        .WIDTH (PAKG_SIZE + 2),
        .DEPTH (SINK_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (do_pop),
        .data_i  ({in_bcast, in_err, data_out}),
        .full_o  (buf_full),
        .pop_i   (out_ready),
        .valid_o (out_valid),
        .head_o  ({out_bcast, out_err, out_data})
    );

    assign pkt_cnt   = pkt_cnt_q;
    assign bcast_cnt = bcast_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_mesh_term_sink.sv
// tb/tb_mesh_term_sink.sv - self-checking bench for mesh_term_sink
module tb_mesh_term_sink;

    localparam int PW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          pndng;
    logic [PW-1:0] data_out;
    logic          out_ready;

    logic          pop, out_valid, out_bcast, out_err;
    logic [PW-1:0] out_data;
    logic [15:0]   pkt_cnt, bcast_cnt, err_cnt;

    logic          s_pop, s_out_valid, s_out_bcast, s_out_err;
    logic [PW-1:0] s_out_data;
    logic [2:0]    s_pkt_cnt, s_bcast_cnt, s_err_cnt;

    always #5 clk = ~clk;

    mesh_term_sink #(.CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .pndng(pndng), .data_out(data_out), .pop(pop),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_bcast(out_bcast), .out_err(out_err),
        .pkt_cnt(pkt_cnt), .bcast_cnt(bcast_cnt), .err_cnt(err_cnt)
    );

    mesh_term_sink #(.CNT_W(3)) u_sat (
        .clk(clk), .reset(reset), .pndng(pndng), .data_out(data_out), .pop(s_pop),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_bcast(s_out_bcast), .out_err(s_out_err),
        .pkt_cnt(s_pkt_cnt), .bcast_cnt(s_bcast_cnt), .err_cnt(s_err_cnt)
    );

    typedef struct packed {
        logic [PW-1:0] d;
        logic          b;
        logic          e;
    } exp_t;

    int            total = 0;
    int            bad   = 0;
    logic [PW-1:0] mesh_q [$];
    exp_t          exp_q  [$];
    int            n_pkt, n_bc, n_er;
    logic          prev_pop;
    int            dut_pops;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t classify(input logic [PW-1:0] d);
        exp_t r;
        r.d = d;
        r.b = (d[31:24] == 8'hFF);
        r.e = !r.b && ((d[23:20] != 4'd1) || (d[19:16] != 4'd0));
        return r;
    endfunction

    function automatic logic [63:0] sat7(input int n);
        return (n > 7) ? 64'd7 : 64'(n);
    endfunction

    function automatic logic [PW-1:0] gen_pkt(input int kind);
        logic [PW-1:0] p;
        p = $urandom();
        case (kind)
            0: p[31:24] = 8'hFF;
            1: begin
                if (p[31:24] == 8'hFF) p[31:24] = 8'h00;
                if (p[23:20] == 4'd1 && p[19:16] == 4'd0) p[19:16] = 4'd3;
            end
            default: begin
                if (p[31:24] == 8'hFF) p[31:24] = 8'h01;
                p[23:20] = 4'd1;
                p[19:16] = 4'd0;
            end
        endcase
        return p;
    endfunction

    // One clock: drive the mesh model, check at the falling edge, advance the model.
    task automatic cycle();
        logic deq, exp_pop;
        int   occ;
        pndng    = (mesh_q.size() != 0);
        data_out = pndng ? mesh_q[0] : PW'($urandom());
        @(negedge clk);
        if (pop === 1'b1) dut_pops++;
        if (!reset) begin
            chk("pop_in_reset", {63'd0, pop}, 64'd0);
            exp_q.delete();
            n_pkt = 0; n_bc = 0; n_er = 0;
            prev_pop = 1'b0;
        end else begin
            deq = (exp_q.size() != 0) && out_ready;
            occ = exp_q.size() - (deq ? 1 : 0);
            exp_pop = pndng && !prev_pop && (occ < DEPTH);
            chk("pop", {63'd0, pop}, {63'd0, exp_pop});
            chk("sat_pop", {63'd0, s_pop}, {63'd0, exp_pop});
            chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                chk("out_data", 64'(out_data), 64'(exp_q[0].d));
                chk("out_bcast", {63'd0, out_bcast}, {63'd0, exp_q[0].b});
                chk("out_err", {63'd0, out_err}, {63'd0, exp_q[0].e});
            end
            chk("pkt_cnt", 64'(pkt_cnt), 64'(n_pkt));
            chk("bcast_cnt", 64'(bcast_cnt), 64'(n_bc));
            chk("err_cnt", 64'(err_cnt), 64'(n_er));
            chk("sat_pkt_cnt", 64'(s_pkt_cnt), sat7(n_pkt));
            chk("sat_bcast_cnt", 64'(s_bcast_cnt), sat7(n_bc));
            chk("sat_err_cnt", 64'(s_err_cnt), sat7(n_er));
            if (deq) void'(exp_q.pop_front());
            if (exp_pop) begin
                exp_t e;
                e = classify(mesh_q.pop_front());
                exp_q.push_back(e);
                n_pkt++;
                if (e.b) n_bc++;
                if (e.e) n_er++;
            end
            prev_pop = exp_pop;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int pops0;
        reset = 1'b0; out_ready = 1'b1; pndng = 1'b0; data_out = '0;
        n_pkt = 0; n_bc = 0; n_er = 0; prev_pop = 1'b0; dut_pops = 0;

        // Reset with packets pending in the mesh.
        for (int i = 0; i < 3; i++) mesh_q.push_back(gen_pkt(2));
        run(3);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_bcast", {63'd0, out_bcast}, 64'd0);
        chk("rst_out_err", {63'd0, out_err}, 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("rst_sat_pkt_cnt", 64'(s_pkt_cnt), 64'd0);
        reset = 1'b1;
        pndng = 1'b1;
        #1;
        chk("first_pop_after_reset", {63'd0, pop}, 64'd1);
        run(12);

        // Single unicast for (1,0).
        mesh_q.push_back(32'h0010_ABCD);
        run(6);
        chk("single_pkt_cnt", 64'(pkt_cnt), 64'd4);
        chk("single_err_cnt", 64'(err_cnt), 64'd0);

        // Ten back-to-back unicasts.
        for (int i = 0; i < 10; i++) mesh_q.push_back(gen_pkt(2));
        run(25);
        chk("burst_pkt_cnt", 64'(pkt_cnt), 64'd14);
        chk("sat_after_burst", 64'(s_pkt_cnt), 64'd7);

        // Backpressure: six offered, only DEPTH accepted until drained.
        out_ready = 1'b0;
        pops0 = dut_pops;
        for (int i = 0; i < 6; i++) mesh_q.push_back(gen_pkt(2));
        run(15);
        chk("bp_pops", 64'(dut_pops - pops0), 64'd4);
        chk("bp_pndng_held", {63'd0, pndng}, 64'd1);
        out_ready = 1'b1;
        run(20);
        chk("bp_drain_pops", 64'(dut_pops - pops0), 64'd6);
        chk("bp_drained", {63'd0, out_valid}, 64'd0);

        // Broadcast then misrouted to (2,3).
        mesh_q.push_back(32'hFF00_1234);
        mesh_q.push_back(32'h0023_5678);
        run(8);
        chk("bc_cnt", 64'(bcast_cnt), 64'd1);
        chk("er_cnt", 64'(err_cnt), 64'd1);

        // Random traffic with random consumer stalls.
        for (int i = 0; i < 300; i++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            if (mesh_q.size() < 3 && $urandom_range(0, 1) == 1)
                mesh_q.push_back(gen_pkt(int'($urandom_range(0, 2))));
            cycle();
        end
        out_ready = 1'b1;
        run(20);

        // Reset with two buffered entries.
        out_ready = 1'b0;
        mesh_q.push_back(gen_pkt(2));
        mesh_q.push_back(gen_pkt(0));
        run(6);
        chk("pre_reset_valid", {63'd0, out_valid}, 64'd1);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        chk("post_reset_valid", {63'd0, out_valid}, 64'd0);
        chk("post_reset_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("post_reset_bcast_cnt", 64'(bcast_cnt), 64'd0);
        chk("post_reset_sat_cnt", 64'(s_pkt_cnt), 64'd0);
        run(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
